// File: rtl/ripple_counter_monitor_pkg.sv
// Shared types and constants for the ripple counter monitor.
// Holds the FSM encoding, datapath widths and the saturating wrap increment.
package ripple_counter_monitor_pkg;

    localparam int COUNT_W = 4;
    localparam int WRAP_W  = 8;
    localparam int STAB_W  = 3;

    localparam logic [WRAP_W-1:0] WRAP_MAX = '1;

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        ACQUIRE  = 2'd1,
        TRACK    = 2'd2
    } mon_state_e;

    // Wrap counter never rolls over; saturation is reported separately.
    function automatic logic [WRAP_W-1:0] wrap_inc(input logic [WRAP_W-1:0] v);
        return (v == WRAP_MAX) ? v : v + WRAP_W'(1);
    endfunction

endpackage

// File: rtl/ripple_counter_monitor_bit_synchronizer.sv
// Single-bit flop chain bringing one asynchronous counter bit into the clock domain.
// Output is the last stage; all stages clear on reset.
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) chain <= '0;
        else          chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/ripple_counter_monitor.sv
// Monitors an asynchronous 4-bit ripple counter: synchronizes, filters ripple
// glitches by requiring stable samples, and counts wrap-arounds.
module ripple_counter_monitor
    import ripple_counter_monitor_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 2
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [COUNT_W-1:0] cnt_in,
    input  logic               enable,
    input  logic               clear,
    output logic [COUNT_W-1:0] count_out,
    output logic               count_valid,
    output logic               wrap_pulse,
    output logic [WRAP_W-1:0]  wrap_count,
    output logic               wrap_sat
);

    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES);

    logic [COUNT_W-1:0] sync_s;
    logic [COUNT_W-1:0] s_prev;
    logic [STAB_W-1:0]  stab_q;
    logic [STAB_W-1:0]  stab_cur;
    logic               accept;

    mon_state_e state_q, state_d;
    logic       take;
    logic       eval_wrap;
    logic       is_wrap;
    logic       do_clear;

    for (genvar i = 0; i < COUNT_W; i++) begin : g_sync
        bit_synchronizer #(.STAGES(SYNC_STAGES)) u_sync (
            .clock   (clock),
            .reset_n (reset_n),
            .d       (cnt_in[i]),
            .q       (sync_s[i])
        );
    end

    // Stability count including the current sample; keeps running while disabled.
    always_comb begin
        stab_cur = stab_q;
        if (sync_s != s_prev)      stab_cur = STAB_W'(1);
        else if (stab_q < STAB_MAX) stab_cur = stab_q + STAB_W'(1);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s_prev <= '0;
            stab_q <= '0;
        end else begin
            s_prev <= sync_s;
            stab_q <= stab_cur;
        end
    end

    assign accept = (stab_cur == STAB_MAX) && (sync_s != count_out);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= DISABLED;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            DISABLED: if (enable) state_d = ACQUIRE;
            ACQUIRE:  if (!enable) state_d = DISABLED;
                      else if (accept) state_d = TRACK;
            TRACK:    if (!enable) state_d = DISABLED;
            default:  state_d = DISABLED;
        endcase
    end

    // The first acceptance after (re)enable only establishes a baseline.
    always_comb begin
        take      = 1'b0;
        eval_wrap = 1'b0;
        case (state_q)
            ACQUIRE: take = enable && accept;
            TRACK: begin
                take      = enable && accept;
                eval_wrap = 1'b1;
            end
            default: ;
        endcase
    end

    assign is_wrap  = take && eval_wrap && (sync_s < count_out);
    assign do_clear = enable && clear;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_out   <= '0;
            count_valid <= 1'b0;
            wrap_pulse  <= 1'b0;
        end else begin
            if (take) count_out <= sync_s;
            count_valid <= take;
            wrap_pulse  <= is_wrap;
        end
    end

    // Clear takes priority over a coincident wrap; the pulse still fires.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wrap_count <= '0;
            wrap_sat   <= 1'b0;
        end else if (do_clear) begin
            wrap_count <= '0;
            wrap_sat   <= 1'b0;
        end else if (is_wrap) begin
            wrap_count <= wrap_inc(wrap_count);
            if (wrap_count == WRAP_MAX) wrap_sat <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ripple_counter_monitor.sv
// Randomized and directed bench for ripple_counter_monitor with an
// input-history based reference model checked every cycle.
module tb_ripple_counter_monitor;

    localparam int SYNC   = 2;
    localparam int STABLE = 2;

    logic       clock;
    logic       reset_n;
    logic [3:0] cnt_in;
    logic       enable;
    logic       clear;
    logic [3:0] count_out;
    logic       count_valid;
    logic       wrap_pulse;
    logic [7:0] wrap_count;
    logic       wrap_sat;

    ripple_counter_monitor #(.SYNC_STAGES(SYNC), .STABLE_CYCLES(STABLE)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .cnt_in      (cnt_in),
        .enable      (enable),
        .clear       (clear),
        .count_out   (count_out),
        .count_valid (count_valid),
        .wrap_pulse  (wrap_pulse),
        .wrap_count  (wrap_count),
        .wrap_sat    (wrap_sat)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    bit chk_on   = 1'b0;

    // Reference model: raw input history, synchronized-sample history, outputs.
    logic [3:0] in_hist[$];
    logic [3:0] s_hist[$];
    int         m_mode;       // 0 off, 1 acquiring, 2 tracking
    logic [3:0] m_count;
    bit         m_valid, m_wrap, m_sat;
    int         m_wcnt;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        in_hist.delete();
        s_hist.delete();
        s_hist.push_front(4'h0);
        m_mode = 0; m_count = 4'h0; m_valid = 0; m_wrap = 0; m_sat = 0; m_wcnt = 0;
    endtask

    task automatic model_step(input bit en, input bit clr, input logic [3:0] cnt);
        int run;
        logic [3:0] s;
        bit acc;
        s   = s_hist[0];
        run = 0;
        for (int i = 0; i < s_hist.size(); i++) begin
            if (s_hist[i] != s) break;
            run++;
        end
        if (run > STABLE) run = STABLE;
        acc = en && (m_mode != 0) && (run == STABLE) && (s != m_count);
        m_valid = 0;
        m_wrap  = 0;
        if (!en) m_mode = 0;
        else if (m_mode == 0) m_mode = 1;
        else if (acc) begin
            m_valid = 1;
            if (m_mode == 2 && s < m_count) begin
                m_wrap = 1;
                if (m_wcnt == 255) m_sat = 1;
                else m_wcnt++;
            end
            m_count = s;
            m_mode  = 2;
        end
        if (en && clr) begin
            m_wcnt = 0;
            m_sat  = 0;
        end
        in_hist.push_front(cnt);
        if (in_hist.size() > 8) void'(in_hist.pop_back());
        s_hist.push_front(in_hist.size() >= SYNC ? in_hist[SYNC-1] : 4'h0);
        if (s_hist.size() > 16) void'(s_hist.pop_back());
    endtask

    always @(negedge clock) begin
        if (chk_on) begin
            chk("count_out",   int'(count_out),   int'(m_count));
            chk("count_valid", int'(count_valid), int'(m_valid));
            chk("wrap_pulse",  int'(wrap_pulse),  int'(m_wrap));
            chk("wrap_count",  int'(wrap_count),  m_wcnt);
            chk("wrap_sat",    int'(wrap_sat),    int'(m_sat));
        end
    end

    task automatic edge_step();
        @(posedge clock);
        if (reset_n) model_step(enable, clear, cnt_in);
    endtask

    task automatic tick();
        edge_step();
        @(negedge clock);
    endtask

    int n_valid, n_wrap;

    task automatic hold(input logic [3:0] v, input int n);
        cnt_in = v;
        for (int i = 0; i < n; i++) begin
            tick();
            n_valid += int'(count_valid);
            n_wrap  += int'(wrap_pulse);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_count_out"},   int'(count_out),   0);
        chk({tag, "_count_valid"}, int'(count_valid), 0);
        chk({tag, "_wrap_pulse"},  int'(wrap_pulse),  0);
        chk({tag, "_wrap_count"},  int'(wrap_count),  0);
        chk({tag, "_wrap_sat"},    int'(wrap_sat),    0);
    endtask

    // Asserts reset part-way through the high phase, independent of the clock edge.
    task automatic async_reset(input string tag);
        edge_step();
        #2 reset_n = 1'b0;
        model_reset();
        #1 check_zero(tag);
        @(negedge clock);
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        bit found;
        reset_n = 1'b0; enable = 1'b0; clear = 1'b0; cnt_in = 4'h0;
        model_reset();
        #2 check_zero("reset");
        chk_on = 1'b1;
        @(negedge clock);
        tick();
        reset_n = 1'b1;
        hold(4'h0, 3);

        // First acceptance lands four edges after enable is sampled.
        enable = 1'b1; cnt_in = 4'h5;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("acq_early_valid", int'(count_valid), 0);
        end
        tick();
        chk("acq_valid", int'(count_valid), 1);
        chk("acq_count", int'(count_out), 5);
        chk("acq_wrap",  int'(wrap_pulse), 0);

        clear = 1'b1; tick(); clear = 1'b0;
        n_valid = 0; n_wrap = 0;
        for (int k = 0; k < 4; k++) begin
            cnt_in = 4'(13 + k);
            for (int i = 0; i < 10; i++) begin
                tick();
                n_valid += int'(count_valid);
                n_wrap  += int'(wrap_pulse);
                if (wrap_pulse) chk("wrap_at_zero", int'(count_out), 0);
            end
        end
        chk("step_valids", n_valid, 4);
        chk("step_wraps",  n_wrap, 1);
        chk("step_wcnt",   int'(wrap_count), 1);

        hold(4'h7, 10);
        n_valid = 0;
        hold(4'h6, 1);
        hold(4'h7, 10);
        chk("glitch_valids", n_valid, 0);
        chk("glitch_count",  int'(count_out), 7);

        clear = 1'b1; tick(); clear = 1'b0;
        hold(4'hF, 6);
        for (int i = 0; i < 255; i++) begin
            hold(4'h0, 6);
            hold(4'hF, 6);
        end
        chk("pre_sat_wcnt", int'(wrap_count), 255);
        chk("pre_sat_flag", int'(wrap_sat), 0);
        hold(4'h0, 6);
        chk("sat_wcnt", int'(wrap_count), 255);
        chk("sat_flag", int'(wrap_sat), 1);
        clear = 1'b1; tick(); clear = 1'b0;
        chk("clr_wcnt", int'(wrap_count), 0);
        chk("clr_flag", int'(wrap_sat), 0);

        hold(4'hC, 6);
        chk("pre_dis_count", int'(count_out), 12);
        enable = 1'b0;
        n_valid = 0;
        hold(4'h2, 8);
        chk("dis_count",  int'(count_out), 12);
        chk("dis_valids", n_valid, 0);
        enable = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            tick();
            if (count_valid) begin
                found = 1'b1;
                chk("reen_count", int'(count_out), 2);
                chk("reen_wrap",  int'(wrap_pulse), 0);
            end
        end
        chk("reen_seen", int'(found), 1);

        hold(4'h9, 6);
        cnt_in = 4'hA;
        tick(); tick();
        async_reset("midacc");
        n_valid = 0;
        enable = 1'b0;
        hold(4'hA, 6);
        chk("post_rst_valids", n_valid, 0);
        chk("post_rst_count",  int'(count_out), 0);

        for (int seg = 0; seg < 600; seg++) begin
            enable = ($urandom_range(0, 19) != 0);
            clear  = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 149) == 0) async_reset("rand");
            hold(4'($urandom_range(0, 15)), $urandom_range(1, 8));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ripple_counter_monitor.md
RIPPLE_COUNTER_MONITOR -- requirements
Module: ripple_counter_monitor

Interface
REQ-001 Parameter: SYNC_STAGES, default 2, synchronizer flops per input bit (legal 2..4).
REQ-002 Parameter: STABLE_CYCLES, default 2, consecutive equal synchronized samples needed to accept a value (legal 1..7).
REQ-003 clock  input  1  system clock; all state is updated on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 cnt_in  input  4  ripple counter bits {q3,q2,q1,q0}; asynchronous to clock and may glitch during ripple.
REQ-006 enable  input  1  synchronous; 1 = track cnt_in, 0 = hold all outputs.
REQ-007 clear  input  1  synchronous; zeroes wrap_count and wrap_sat.
REQ-008 count_out  output  4  last accepted stable value of cnt_in.
REQ-009 count_valid  output  1  one-cycle pulse when count_out takes a new value.
REQ-010 wrap_pulse  output  1  one-cycle pulse when an accepted value indicates counter wrap-around.
REQ-011 wrap_count  output  8  number of wraps detected since reset or clear.
REQ-012 wrap_sat  output  1  sticky flag; set when wrap_count would exceed 8'hFF.

Function
REQ-013 Each cnt_in bit SHALL pass through its own SYNC_STAGES-deep flop chain; the chain output is the synchronized sample S.
REQ-014 The stability counter SHALL reset to 1 when S differs from its previous value, and otherwise SHALL increment, saturating at STABLE_CYCLES.
REQ-015 S SHALL be accepted when the stability counter equals STABLE_CYCLES and S differs from count_out; count_out SHALL load S on the next edge, with count_valid high for exactly that cycle.
REQ-016 Latency from a clean cnt_in change to count_out update SHALL be SYNC_STAGES+STABLE_CYCLES cycles (4 with defaults).
REQ-017 FSM states: DISABLED, ACQUIRE, TRACK.
- DISABLED->ACQUIRE on enable=1.
- ACQUIRE->TRACK on the first acceptance.
- Any state->DISABLED on enable=0.
REQ-018 In ACQUIRE, the first accepted value SHALL load count_out and pulse count_valid, but SHALL NOT be evaluated for wrap.
REQ-019 In TRACK, an accepted value numerically less than the current count_out SHALL be a wrap: wrap_pulse is high in the same cycle as count_valid, and wrap_count increments by 1.
- This also covers skipped values, e.g. 14->1.
REQ-020 An increment from 8'hFF SHALL hold wrap_count at 8'hFF and set wrap_sat.
REQ-021 clear=1 SHALL zero wrap_count and wrap_sat on the next edge; if a wrap occurs in the same cycle, clear wins (wrap_count=0) but wrap_pulse still fires.
REQ-022 In DISABLED, the synchronizer SHALL keep running; count_out, wrap_count and wrap_sat SHALL hold; count_valid and wrap_pulse SHALL stay 0.
REQ-023 Re-enable SHALL enter ACQUIRE, so no wrap is reported across a disabled interval.
REQ-024 An accepted value equal to count_out SHALL produce no pulses (unreachable by REQ-015; kept as a safety rule).

Reset
REQ-025 reset_n=0 SHALL immediately clear all synchronizer flops, the stability counter, count_out=4'h0, count_valid=0, wrap_pulse=0, wrap_count=8'h00, wrap_sat=0, and FSM=DISABLED.
REQ-026 Reset asserted mid-acceptance SHALL abort it with no pulse; after release, operation restarts per REQ-017.
REQ-027 Reset release SHALL be synchronized to clock externally; this block needs no release synchronizer.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding (2 bits) and the constants COUNT_W=4, WRAP_W=8.
REQ-029 The per-bit flop chain SHALL be a sub-module named bit_synchronizer (parameter STAGES), instantiated 4 times.
REQ-030 The stability filter, FSM and wrap counter SHALL live in ripple_counter_monitor.

Verification
REQ-031 Reset, then enable=1, hold cnt_in=4'h5 -> count_out=4'h5 with one count_valid pulse exactly 4 cycles after enable sampling; wrap_pulse=0.
REQ-032 In TRACK, step cnt_in 13,14,15,0, each held 10 cycles -> four count_valid pulses; one wrap_pulse, coincident with count_out=0; wrap_count=1.
REQ-033 Hold cnt_in=4'h7, then glitch to 4'h6 for 1 cycle and return to 7 -> no count_valid pulse; count_out stays 7.
REQ-034 Preload wrap_count=8'hFF via 255 wraps, then one more wrap -> wrap_count=8'hFF, wrap_sat=1; then clear=1 -> both 0.
REQ-035 Accept 4'hC, set enable=0, change cnt_in to 4'h2, re-enable -> count_out=2, count_valid pulses, no wrap_pulse.
REQ-036 Assert reset_n=0 asynchronously mid-way through a 9->10 acceptance -> all outputs 0 at once, no pulse; after release, FSM is in DISABLED.
